// File: rtl/risc_ctrl_pkg.sv
// Shared encodings for the RISC core execution controller: FSM states and display widths.
// Pure declarations; no logic, no latency.
package risc_ctrl_pkg;

  localparam int STATE_W    = 3;
  localparam int STEP_CNT_W = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_STEP = 3'd1,
    ST_RUN  = 3'd2,
    ST_WAIT = 3'd3,
    ST_HALT = 3'd4
  } state_e;

  function automatic logic state_runs_cpu(input state_e s);
    return (s == ST_STEP) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-flop sync, stability filter, one-cycle press on debounced 1->0.
// Press appears 2+DEB_CYCLES cycles after a clean edge; no backpressure, pulses are not held.
module key_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((DEB_CYCLES > 0) ? DEB_CYCLES - 1 : 0);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level   <= 1'b1;
      level_d <= 1'b1;
      cnt     <= '0;
    end else begin
      sync1   <= btn_n;
      sync2   <= sync1;
      level_d <= level;
      // Any sample agreeing with the accepted level restarts the stability window.
      if (sync2 != level) begin
        if (cnt == CNT_MAX) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = level_d & ~level;

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable controller: single-step per press, paced run with breakpoint, sticky halt.
// Outputs decoded from registered state; instr_done takes effect on the next edge, no stalls.
module cpu_step_ctrl
  import risc_ctrl_pkg::*;
#(
  parameter int PC_W       = 8,
  parameter int DEB_CYCLES = 500000,
  parameter int RUN_DIV    = 25000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  step_btn_n,
  input  logic                  run_sw,
  input  logic                  instr_done,
  input  logic                  halt_in,
  input  logic [PC_W-1:0]       pc,
  input  logic [PC_W-1:0]       bp_addr,
  input  logic                  bp_en,
  output logic                  cpu_en,
  output logic [STATE_W-1:0]    state,
  output logic [STEP_CNT_W-1:0] step_count,
  output logic                  bp_hit
);

  localparam int PACE_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [PACE_W-1:0] PACE_LOAD = PACE_W'((RUN_DIV > 0) ? RUN_DIV - 1 : 0);

  state_e                  state_q;
  state_e                  state_d;
  logic [PACE_W-1:0]       pace_q;
  logic [STEP_CNT_W-1:0]   step_count_q;
  logic                    bp_hit_q;
  logic                    press;
  logic                    done;
  logic                    bp_match;
  logic                    load_pace;
  logic                    set_bp;
  logic                    clr_bp;

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk   (clk),
    .reset (reset),
    .btn_n (step_btn_n),
    .press (press)
  );

  assign cpu_en   = state_runs_cpu(state_q);
  assign done     = instr_done & cpu_en;
  assign bp_match = bp_en && (pc == bp_addr);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_pace = 1'b0;
    set_bp    = 1'b0;
    clr_bp    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run_sw) begin
          state_d = ST_RUN;
          clr_bp  = 1'b1;
        end else if (press) begin
          state_d = ST_STEP;
          clr_bp  = 1'b1;
        end
      end
      ST_STEP: begin
        if (done) state_d = halt_in ? ST_HALT : ST_IDLE;
      end
      ST_RUN: begin
        // Decisions are taken only at instruction boundaries so nothing is cut short.
        if (done) begin
          if (halt_in) begin
            state_d = ST_HALT;
          end else if (bp_match) begin
            state_d = ST_IDLE;
            set_bp  = 1'b1;
          end else if (!run_sw) begin
            state_d = ST_IDLE;
          end else if (RUN_DIV == 0) begin
            state_d = ST_RUN;
          end else begin
            state_d   = ST_WAIT;
            load_pace = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (!run_sw)          state_d = ST_IDLE;
        else if (pace_q == 0) state_d = ST_RUN;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pace_q       <= '0;
      step_count_q <= '0;
      bp_hit_q     <= 1'b0;
    end else begin
      if (load_pace)
        pace_q <= PACE_LOAD;
      else if (state_q == ST_WAIT && pace_q != '0)
        pace_q <= pace_q - PACE_W'(1);

      if (done) step_count_q <= step_count_q + STEP_CNT_W'(1);

      if (clr_bp)      bp_hit_q <= 1'b0;
      else if (set_bp) bp_hit_q <= 1'b1;
    end
  end

  assign state      = state_q;
  assign step_count = step_count_q;
  assign bp_hit     = bp_hit_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with DEB_CYCLES=4, RUN_DIV=3 and a fixed-length CPU model.
// The CPU model retires one instruction per instr_len enabled cycles; pc reports the next address.
module tb_cpu_step_ctrl;

  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            step_btn_n = 1'b1;
  logic            run_sw = 1'b0;
  logic            instr_done;
  logic            halt_in = 1'b0;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] bp_addr = 8'h00;
  logic            bp_en = 1'b0;
  logic            cpu_en;
  logic [2:0]      state;
  logic [15:0]     step_count;
  logic            bp_hit;

  int              n_checks = 0;
  int              n_fail = 0;
  int              instr_len = 4;
  int              en_cnt = 0;
  int              press_total = 0;
  logic [PC_W-1:0] pc_exec = 8'h01;

  localparam logic [2:0] S_IDLE = 3'd0, S_STEP = 3'd1, S_RUN = 3'd2, S_WAIT = 3'd3, S_HALT = 3'd4;

  cpu_step_ctrl #(
    .PC_W(PC_W), .DEB_CYCLES(4), .RUN_DIV(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .step_btn_n (step_btn_n),
    .run_sw     (run_sw),
    .instr_done (instr_done),
    .halt_in    (halt_in),
    .pc         (pc),
    .bp_addr    (bp_addr),
    .bp_en      (bp_en),
    .cpu_en     (cpu_en),
    .state      (state),
    .step_count (step_count),
    .bp_hit     (bp_hit)
  );

  always #5 clk = ~clk;

  assign instr_done = cpu_en && (en_cnt == instr_len - 1);
  assign pc         = pc_exec + 8'd1;

  always @(posedge clk) begin
    if (reset) begin
      en_cnt  <= 0;
      pc_exec <= 8'h01;
    end else if (cpu_en) begin
      if (instr_done) begin
        en_cnt  <= 0;
        pc_exec <= pc_exec + 8'd1;
      end else begin
        en_cnt <= en_cnt + 1;
      end
    end
  end

  always @(posedge clk) if (dut.u_deb.press) press_total <= press_total + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n = 0;
    while (state != s && n < budget) begin
      tick();
      n++;
    end
    chk("wait_state", 32'(state), 32'(s));
  endtask

  initial begin
    logic [13:0] pat;
    logic        bounce [8];
    int          on_cnt;
    int          p0;

    // Clean press: pulse after 6 cycles, one 4-cycle STEP.
    do_reset();
    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_cpu_en", 32'(cpu_en), 32'd0);
    chk("rst_count", 32'(step_count), 32'd0);
    chk("rst_bp_hit", 32'(bp_hit), 32'd0);
    step_btn_n = 1'b0;
    repeat (5) tick();
    chk("press_early", 32'(dut.u_deb.press), 32'd0);
    tick();
    chk("press_at_6", 32'(dut.u_deb.press), 32'd1);
    chk("idle_at_6", 32'(state), 32'(S_IDLE));
    tick();
    chk("step_entry", 32'(state), 32'(S_STEP));
    on_cnt = int'(cpu_en);
    repeat (3) begin
      tick();
      on_cnt += int'(cpu_en);
    end
    step_btn_n = 1'b1;
    tick();
    chk("step_on_cycles", 32'(on_cnt), 32'd4);
    chk("step_exit", 32'(state), 32'(S_IDLE));
    chk("step_exit_en", 32'(cpu_en), 32'd0);
    chk("step_count1", 32'(step_count), 32'd1);
    repeat (10) tick();
    chk("release_no_step", 32'(step_count), 32'd1);

    // Bounce filtering and press discarded while stepping.
    do_reset();
    instr_len = 24;
    p0 = press_total;
    bounce = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    foreach (bounce[i]) begin
      step_btn_n = bounce[i];
      tick();
    end
    step_btn_n = 1'b0;
    wait_state(S_STEP, 20);
    chk("bounce_one_press", 32'(press_total - p0), 32'd1);
    step_btn_n = 1'b1;
    repeat (7) tick();
    step_btn_n = 1'b0;
    repeat (7) tick();
    chk("press_in_step", 32'(press_total - p0), 32'd2);
    chk("still_step", 32'(state), 32'(S_STEP));
    wait_state(S_IDLE, 30);
    chk("bounce_count", 32'(step_count), 32'd1);
    repeat (3) tick();
    chk("press_not_queued", 32'(state), 32'(S_IDLE));
    step_btn_n = 1'b1;
    instr_len = 4;
    repeat (8) tick();

    // Run mode pacing, then run_sw dropped mid-instruction.
    do_reset();
    run_sw = 1'b1;
    tick();
    for (int i = 0; i < 14; i++) begin
      pat[i] = cpu_en;
      tick();
    end
    chk("run_pattern", 32'(pat), 32'h078F);
    chk("run_third_on", 32'(cpu_en), 32'd1);
    tick();
    run_sw = 1'b0;
    tick();
    chk("run_completes", 32'(state), 32'(S_RUN));
    repeat (2) tick();
    chk("run_stop_idle", 32'(state), 32'(S_IDLE));
    chk("run_count3", 32'(step_count), 32'd3);

    // Breakpoint at 0x05, then resume executes that instruction.
    do_reset();
    bp_en   = 1'b1;
    bp_addr = 8'h05;
    run_sw  = 1'b1;
    tick();
    repeat (22) tick();
    run_sw = 1'b0;
    repeat (3) tick();
    chk("bp_state", 32'(state), 32'(S_IDLE));
    chk("bp_hit_set", 32'(bp_hit), 32'd1);
    chk("bp_count4", 32'(step_count), 32'd4);
    run_sw = 1'b1;
    tick();
    chk("bp_resume_run", 32'(state), 32'(S_RUN));
    chk("bp_hit_clr", 32'(bp_hit), 32'd0);
    repeat (4) tick();
    chk("bp_passed_wait", 32'(state), 32'(S_WAIT));
    chk("bp_count5", 32'(step_count), 32'd5);
    run_sw = 1'b0;
    tick();
    chk("wait_abort", 32'(state), 32'(S_IDLE));
    bp_en = 1'b0;

    // Halt is sticky until reset.
    do_reset();
    run_sw  = 1'b1;
    halt_in = 1'b1;
    tick();
    repeat (4) tick();
    chk("halt_state", 32'(state), 32'(S_HALT));
    chk("halt_en", 32'(cpu_en), 32'd0);
    chk("halt_count", 32'(step_count), 32'd1);
    halt_in = 1'b0;
    run_sw  = 1'b0;
    repeat (3) tick();
    run_sw = 1'b1;
    repeat (3) tick();
    step_btn_n = 1'b0;
    repeat (10) tick();
    step_btn_n = 1'b1;
    repeat (8) tick();
    chk("halt_sticky", 32'(state), 32'(S_HALT));
    chk("halt_sticky_cnt", 32'(step_count), 32'd1);
    run_sw = 1'b0;
    do_reset();
    chk("halt_reset", 32'(state), 32'(S_IDLE));
    chk("halt_reset_cnt", 32'(step_count), 32'd0);

    // Counter wrap from 0xFFFF, then reset mid-instruction.
    force dut.step_count_q = 16'hFFFF;
    tick();
    release dut.step_count_q;
    tick();
    chk("preload", 32'(step_count), 32'h0000FFFF);
    run_sw = 1'b1;
    tick();
    repeat (4) tick();
    chk("wrap", 32'(step_count), 32'd0);
    repeat (4) tick();
    chk("mid_instr_en", 32'(cpu_en), 32'd1);
    reset  = 1'b1;
    run_sw = 1'b0;
    tick();
    chk("rst_mid_en", 32'(cpu_en), 32'd0);
    chk("rst_mid_state", 32'(state), 32'(S_IDLE));
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
